rv_fifo_buffer: RTL and testbench

Parametrised ready/valid FIFO buffer; next generation of the single-slot ready/valid buffer placed between `data_source` and `data_sink`. Decouples producer and consumer by up to `DEPTH` words, reports occupancy and an almost-full flag, and supports a synchronous flush. Drops into the existing source→buffer→sink bench with unchanged handshake port names.

---
 rtl/rv_fifo_buffer.sv | 63 ++++++
 tb/tb_rv_fifo_buffer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rv_fifo_buffer.sv
// rv_fifo_buffer: ready/valid FIFO with occupancy count, almost-full flag and synchronous flush.
// Define RV_FIFO_FALLTHROUGH_EN for zero-latency pass-through when empty.
module rv_fifo_buffer #(
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH        = 4,
   parameter int AFULL_THRESH = DEPTH - 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         almost_full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   assign w_empty     = r_count == '0;
   assign in_ready    = rst && !flush && (r_count != CW'(DEPTH));
   assign count       = r_count;
   assign almost_full = r_count >= CW'(AFULL_THRESH);
`ifdef RV_FIFO_FALLTHROUGH_EN
   // An empty FIFO forwards the upstream word; it is stored only if downstream stalls.
   assign out_valid = rst && !flush && (w_empty ? in_valid : 1'b1);
   assign out_data  = !rst ? '0 : w_empty ? in_data : r_mem[r_rd_ptr];
   assign w_push    = in_valid && in_ready && !(w_empty && out_ready);
   assign w_pop     = out_valid && out_ready && !w_empty;
`else
   assign out_valid = rst && !flush && !w_empty;
   assign out_data  = (rst && !w_empty) ? r_mem[r_rd_ptr] : '0;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
`endif
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(w_push);
         r_rd_ptr <= r_rd_ptr + AW'(w_pop);
         r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= in_data;
   end
endmodule

// File: tb/tb_rv_fifo_buffer.sv
// tb_rv_fifo_buffer: directed vector table plus hand sequences for rv_fifo_buffer (DEPTH=4).
module tb_rv_fifo_buffer;
   logic       clk = 1'b0;
   logic       rst, flush, in_valid, in_ready, out_valid, out_ready, almost_full;
   logic [7:0] in_data, out_data;
   logic [2:0] count;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      logic       r, f, iv, o, chk;
      logic [7:0] id;
      logic       ir, ov, af;
      logic [7:0] od;
      logic [2:0] cnt;
   } vec_t;

   vec_t vecs[$];

   rv_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_THRESH(3)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .count(count), .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic f, logic iv, logic [7:0] id, logic o,
                               logic ir, logic ov, logic [7:0] od, logic [2:0] cnt, logic af);
      vec_t v;
      v.r = r; v.f = f; v.iv = iv; v.id = id; v.o = o; v.chk = 1'b1;
      v.ir = ir; v.ov = ov; v.od = od; v.cnt = cnt; v.af = af;
      return v;
   endfunction

   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic r, logic f, logic iv, logic [7:0] id, logic o);
      rst = r; flush = f; in_valid = iv; in_data = id; out_ready = o;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      logic       exp_ov;
      logic [7:0] exp_od;
      drive(1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
      // Reset held with in_valid high; first row only establishes state.
      v = mk(0,0,1,8'h99,0, 0,0,8'h00,0,0); v.chk = 1'b0; vecs.push_back(v);
      vecs.push_back(mk(0,0,1,8'h99,0, 0,0,8'h00,0,0));
      vecs.push_back(mk(0,0,1,8'h99,0, 0,0,8'h00,0,0));
      vecs.push_back(mk(1,0,0,8'h00,0, 1,0,8'h00,0,0));
      // Fill to full; fifth word is held off.
      vecs.push_back(mk(1,0,1,8'h11,0, 1,0,8'h00,0,0));
      vecs.push_back(mk(1,0,1,8'h22,0, 1,1,8'h11,1,0));
      vecs.push_back(mk(1,0,1,8'h33,0, 1,1,8'h11,2,0));
      vecs.push_back(mk(1,0,1,8'h44,0, 1,1,8'h11,3,1));
      vecs.push_back(mk(1,0,1,8'h55,0, 0,1,8'h11,4,1));
      vecs.push_back(mk(1,0,1,8'h55,0, 0,1,8'h11,4,1));
      // Drain; push offered while full with a pop is refused.
      vecs.push_back(mk(1,0,1,8'h55,1, 0,1,8'h11,4,1));
      vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'h22,3,1));
      vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'h33,2,0));
      vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'h44,1,0));
      vecs.push_back(mk(1,0,0,8'h00,0, 1,0,8'h00,0,0));
      // Streaming at count=2 across several pointer wraps.
      vecs.push_back(mk(1,0,1,8'h60,0, 1,0,8'h00,0,0));
      vecs.push_back(mk(1,0,1,8'h61,0, 1,1,8'h60,1,0));
      for (int k = 0; k < 10; k++)
         vecs.push_back(mk(1,0,1,8'(8'h62 + k),1, 1,1,8'(8'h60 + k),2,0));
      vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'h6A,2,0));
      vecs.push_back(mk(1,0,0,8'h00,1, 1,1,8'h6B,1,0));
      vecs.push_back(mk(1,0,0,8'h00,0, 1,0,8'h00,0,0));
      // Flush at count=3 blocks both handshakes.
      vecs.push_back(mk(1,0,1,8'h71,0, 1,0,8'h00,0,0));
      vecs.push_back(mk(1,0,1,8'h72,0, 1,1,8'h71,1,0));
      vecs.push_back(mk(1,0,1,8'h73,0, 1,1,8'h71,2,0));
      vecs.push_back(mk(1,1,1,8'h74,1, 0,0,8'h71,3,1));
      vecs.push_back(mk(1,0,0,8'h00,0, 1,0,8'h00,0,0));
      // Reset mid-transfer discards stored data.
      vecs.push_back(mk(1,0,1,8'h81,0, 1,0,8'h00,0,0));
      vecs.push_back(mk(0,0,1,8'h82,1, 0,0,8'h00,1,0));
      vecs.push_back(mk(1,0,0,8'h00,0, 1,0,8'h00,0,0));

      step();
      foreach (vecs[i]) begin
         v = vecs[i];
         drive(v.r, v.f, v.iv, v.id, v.o);
         exp_ov = v.ov;
         exp_od = v.od;
`ifdef RV_FIFO_FALLTHROUGH_EN
         if (v.cnt == 0 && v.r && !v.f && v.iv) begin
            exp_ov = 1'b1;
            exp_od = v.id;
         end
`endif
         @(negedge clk);
         if (v.chk) begin
            check($sformatf("v%0d in_ready", i), 8'(in_ready), 8'(v.ir));
            check($sformatf("v%0d out_valid", i), 8'(out_valid), 8'(exp_ov));
            check($sformatf("v%0d out_data", i), out_data, exp_od);
            check($sformatf("v%0d count", i), 8'(count), 8'(v.cnt));
            check($sformatf("v%0d almost_full", i), 8'(almost_full), 8'(v.af));
         end
         step();
      end

      // Full with simultaneous pop: push refused, then one cycle later both complete.
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, 1, 8'(8'hC0 + k), 0);
         step();
      end
      drive(1, 0, 1, 8'hC4, 1);
      #1;
      check("full count", 8'(count), 8'd4);
      check("full in_ready", 8'(in_ready), 8'd0);
      check("full head", out_data, 8'hC0);
      step();
      check("after pop count", 8'(count), 8'd3);
      check("after pop in_ready", 8'(in_ready), 8'd1);
      check("after pop head", out_data, 8'hC1);
      step();
      check("push+pop count", 8'(count), 8'd3);
      check("push+pop head", out_data, 8'hC2);
      drive(1, 0, 0, 8'h00, 1);
      for (int k = 2; k < 5; k++) begin
         #1;
         check($sformatf("tail %0d", k), out_data, 8'(8'hC0 + k));
         step();
      end
      check("drained count", 8'(count), 8'd0);
      check("drained out_valid", 8'(out_valid), 8'd0);

`ifdef RV_FIFO_FALLTHROUGH_EN
      drive(1, 0, 1, 8'hA5, 1);
      #1;
      check("ft out_valid", 8'(out_valid), 8'd1);
      check("ft out_data", out_data, 8'hA5);
      check("ft count", 8'(count), 8'd0);
      step();
      drive(1, 0, 0, 8'h00, 0);
      #1;
      check("ft count after", 8'(count), 8'd0);
      check("ft out_valid after", 8'(out_valid), 8'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
